rr_arb4: RTL and testbench

RR_ARB4 -- requirements
Module: rr_arb4

---
 rtl/rr_arb4.sv | 169 ++++++++++++++++
 tb/tb_rr_arb4.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb4.sv
// rr_arb4: four-way round-robin arbiter with a bounded hold time per grant.
// Latency: one cycle, request sampled on edge n appears on gnt/gnt_id/busy right after edge n.
// Backpressure: none; an owner keeps the grant while it requests, up to MAX_HOLD cycles, en=0 revokes it.
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst     in   1  asynchronous active-high reset
//   en      in   1  arbitration enable; low releases any grant and blocks new ones
//   req     in   4  request lines, bit i for requester i
//   gnt     out  4  registered one-hot grant (all zero when idle)
//   gnt_id  out  2  registered index of the current owner (0 when idle)
//   busy    out  1  registered, high while a grant is active
//
// MAX_HOLD must lie in 1..255; the hold counter is 8 bits wide.

module rr_arb4 #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

   // Architectural state
   state_t     state_q, state_d;
   logic [1:0] ptr_q,   ptr_d;
   logic [7:0] cnt_q,   cnt_d;
   logic [3:0] gnt_q,   gnt_d;
   logic [1:0] id_q,    id_d;
   logic       busy_q,  busy_d;

   // Decision terms
   logic       hold;
   logic       rel;
   logic [1:0] scan_base;
   logic [3:0] req_rot;
   logic       pick_vld;
   logic [1:0] pick_off;
   logic [1:0] pick_idx;

   // -------------------------------------------------------------------
   // Hold / release decision for the current owner.
   // A single release covers every cause at once (drop, limit, disable),
   // so the pointer can only advance once per edge.
   // -------------------------------------------------------------------
   always_comb begin
      hold = (state_q == ST_GRANT) && en && req[id_q] && (cnt_q < HOLD_LIMIT);
      rel  = (state_q == ST_GRANT) && !hold;
      ptr_d = ptr_q;
      if (rel) begin
         ptr_d = id_q + 2'd1;
      end
      // Search from the post-release pointer so a back-to-back grant
      // already sees the releasing owner as lowest priority.
      scan_base = ptr_d;
   end

   // -------------------------------------------------------------------
   // Rotate the request vector so bit 0 is the highest-priority slot,
   // then take the lowest set bit and rotate the offset back.
   // -------------------------------------------------------------------
   always_comb begin
      req_rot = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         req_rot[i] = req[2'(scan_base + 2'(i))];
      end
   end

   always_comb begin
      pick_vld = 1'b1;
      pick_off = 2'd0;
      if (req_rot[0]) begin
         pick_off = 2'd0;
      end else if (req_rot[1]) begin
         pick_off = 2'd1;
      end else if (req_rot[2]) begin
         pick_off = 2'd2;
      end else if (req_rot[3]) begin
         pick_off = 2'd3;
      end else begin
         pick_vld = 1'b0;
      end
      pick_idx = scan_base + pick_off;
   end

   // -------------------------------------------------------------------
   // Next-state logic for the FSM and its registered outputs.
   // -------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      busy_d  = busy_q;

      if (hold) begin
         cnt_d = cnt_q + 8'd1;
      end else if (en && pick_vld) begin
         // Covers both a fresh grant from IDLE and a back-to-back
         // hand-over on release; the count restarts at one.
         state_d = ST_GRANT;
         id_d    = pick_idx;
         gnt_d   = 4'b0001 << pick_idx;
         busy_d  = 1'b1;
         cnt_d   = 8'd1;
      end else begin
         state_d = ST_IDLE;
         id_d    = 2'd0;
         gnt_d   = 4'b0000;
         busy_d  = 1'b0;
         cnt_d   = 8'd0;
      end
   end

   // -------------------------------------------------------------------
   // State register; reset clears everything immediately.
   // -------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= 2'd0;
         cnt_q   <= 8'd0;
         gnt_q   <= 4'b0000;
         id_q    <= 2'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = id_q;
   assign busy   = busy_q;

   // -------------------------------------------------------------------
   // Output invariants
   // -------------------------------------------------------------------
   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
      $onehot0(gnt_q));

   a_gnt_matches_id : assert property (@(posedge clk) disable iff (rst)
      busy_q |-> gnt_q[id_q]);

   a_idle_id_zero : assert property (@(posedge clk) disable iff (rst)
      !busy_q |-> (id_q == 2'd0 && gnt_q == 4'b0000));

   a_busy_state : assert property (@(posedge clk) disable iff (rst)
      busy_q == (state_q == ST_GRANT));

   a_cnt_bound : assert property (@(posedge clk) disable iff (rst)
      busy_q |-> (cnt_q >= 8'd1 && cnt_q <= HOLD_LIMIT));

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: directed scenarios plus a randomized run checked
// against a rule-level reference model, on MAX_HOLD=8 and MAX_HOLD=1 copies.

module tb_rr_arb4;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] req;

   logic [3:0] gnt8, gnt1;
   logic [1:0] id8,  id1;
   logic       busy8, busy1;

   int checks = 0;
   int errors = 0;

   rr_arb4 #(.MAX_HOLD(8)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req),
      .gnt(gnt8), .gnt_id(id8), .busy(busy8)
   );

   rr_arb4 #(.MAX_HOLD(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .req(req),
      .gnt(gnt1), .gnt_id(id1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model: index 0 mirrors MAX_HOLD=8, index 1 MAX_HOLD=1.
   // ------------------------------------------------------------------
   int mh      [2] = '{8, 1};
   bit m_busy  [2];
   int m_owner [2];
   int m_ptr   [2];
   int m_cnt   [2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_owner[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_busy[k] && en && req[2'(m_owner[k])] && m_cnt[k] < mh[k]) begin
               m_cnt[k] = m_cnt[k] + 1;
            end else begin
               if (m_busy[k]) m_ptr[k] = (m_owner[k] + 1) % 4;
               m_busy[k] = 1'b0; m_owner[k] = 0; m_cnt[k] = 0;
               if (en) begin
                  for (int j = 0; j < 4; j++) begin
                     if (!m_busy[k] && req[2'((m_ptr[k] + j) % 4)]) begin
                        m_busy[k]  = 1'b1;
                        m_owner[k] = (m_ptr[k] + j) % 4;
                        m_cnt[k]   = 1;
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; req = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; req = 4'b1111;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({busy8, id8, gnt8} !== 7'b0) begin
         errors++; $display("FAIL reset_out8: got busy=%b id=%0d gnt=%b, want all zero", busy8, id8, gnt8);
      end
      checks++;
      if ({busy1, id1, gnt1} !== 7'b0) begin
         errors++; $display("FAIL reset_out1: got busy=%b id=%0d gnt=%b, want all zero", busy1, id1, gnt1);
      end
      checks++;
      if (dut.ptr_q !== 2'd0 || dut.cnt_q !== 8'd0) begin
         errors++; $display("FAIL reset_state: got ptr=%0d cnt=%0d, want 0 0", dut.ptr_q, dut.cnt_q);
      end
      rst = 1'b0; en = 1'b0; req = 4'b0000;
   endtask

   task automatic test_first_grant();
      do_reset();
      req = 4'b1010; en = 1'b1;
      @(negedge clk);
      checks++;
      if (gnt8 !== 4'b0010 || id8 !== 2'd1 || busy8 !== 1'b1) begin
         errors++; $display("FAIL first_grant: got gnt=%b id=%0d busy=%b, want 0010 1 1", gnt8, id8, busy8);
      end
   endtask

   task automatic test_rotation();
      int exp_id;
      do_reset();
      req = 4'b1111; en = 1'b1;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         exp_id = (t / 8) % 4;
         checks++;
         if (busy8 !== 1'b1 || id8 !== 2'(exp_id) || gnt8 !== (4'b0001 << exp_id)) begin
            errors++; $display("FAIL rotation8 t=%0d: got busy=%b id=%0d gnt=%b, want busy=1 id=%0d", t, busy8, id8, gnt8, exp_id);
         end
         exp_id = t % 4;
         checks++;
         if (busy1 !== 1'b1 || id1 !== 2'(exp_id) || gnt1 !== (4'b0001 << exp_id)) begin
            errors++; $display("FAIL rotation1 t=%0d: got busy=%b id=%0d gnt=%b, want busy=1 id=%0d", t, busy1, id1, gnt1, exp_id);
         end
      end
   endtask

   task automatic test_owner_drop();
      do_reset();
      req = 4'b0100; en = 1'b1;
      @(negedge clk);
      checks++;
      if (id8 !== 2'd2 || busy8 !== 1'b1) begin
         errors++; $display("FAIL drop_grant2: got id=%0d busy=%b, want 2 1", id8, busy8);
      end
      // Non-owner request appears and changes; grant must stay with 2.
      req = 4'b0101;
      @(negedge clk);
      req = 4'b1101;
      @(negedge clk);
      checks++;
      if (id8 !== 2'd2 || dut.cnt_q !== 8'd3) begin
         errors++; $display("FAIL drop_hold: got id=%0d cnt=%0d, want 2 3", id8, dut.cnt_q);
      end
      req = 4'b0001;
      @(negedge clk);
      checks++;
      if (gnt8 !== 4'b0001 || dut.ptr_q !== 2'd3 || dut.cnt_q !== 8'd1) begin
         errors++; $display("FAIL drop_handover: got gnt=%b ptr=%0d cnt=%0d, want 0001 3 1", gnt8, dut.ptr_q, dut.cnt_q);
      end
   endtask

   task automatic test_enable_drop();
      do_reset();
      req = 4'b0010; en = 1'b1;
      @(negedge clk);
      checks++;
      if (id8 !== 2'd1 || busy8 !== 1'b1) begin
         errors++; $display("FAIL en_grant1: got id=%0d busy=%b, want 1 1", id8, busy8);
      end
      en = 1'b0;
      @(negedge clk);
      checks++;
      if (busy8 !== 1'b0 || gnt8 !== 4'b0000 || dut.ptr_q !== 2'd2) begin
         errors++; $display("FAIL en_release: got busy=%b gnt=%b ptr=%0d, want 0 0000 2", busy8, gnt8, dut.ptr_q);
      end
      en = 1'b1; req = 4'b0010;
      @(negedge clk);
      checks++;
      if (gnt8 !== 4'b0010 || id8 !== 2'd1 || busy8 !== 1'b1) begin
         errors++; $display("FAIL en_regrant: got gnt=%b id=%0d busy=%b, want 0010 1 1", gnt8, id8, busy8);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b1111; en = 1'b1;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy8, id8, gnt8} !== 7'b0 || dut.ptr_q !== 2'd0 || dut.cnt_q !== 8'd0) begin
         errors++; $display("FAIL async_reset: got busy=%b id=%0d gnt=%b ptr=%0d cnt=%0d, want all zero", busy8, id8, gnt8, dut.ptr_q, dut.cnt_q);
      end
      @(negedge clk);
      rst = 1'b0; req = 4'b1000;
      @(negedge clk);
      checks++;
      if (id8 !== 2'd3 || gnt8 !== 4'b1000 || busy8 !== 1'b1) begin
         errors++; $display("FAIL async_regrant: got id=%0d gnt=%b busy=%b, want 3 1000 1", id8, gnt8, busy8);
      end
   endtask

   task automatic test_max_hold_one();
      do_reset();
      req = 4'b1000; en = 1'b1;
      for (int t = 0; t < 10; t++) begin
         @(posedge clk);
         #1;
         checks++;
         if (gnt1 !== 4'b1000 || busy1 !== 1'b1 || dut1.cnt_q !== 8'd1) begin
            errors++; $display("FAIL hold1 t=%0d: got gnt=%b busy=%b cnt=%0d, want 1000 1 1", t, gnt1, busy1, dut1.cnt_q);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] eg;
      do_reset();
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         eg = m_busy[0] ? (4'b0001 << m_owner[0]) : 4'b0000;
         checks++;
         if (busy8 !== m_busy[0] || id8 !== 2'(m_owner[0]) || gnt8 !== eg || dut.ptr_q !== 2'(m_ptr[0])) begin
            errors++; $display("FAIL random8 t=%0d: got busy=%b id=%0d gnt=%b ptr=%0d, want busy=%b id=%0d gnt=%b ptr=%0d",
                               t, busy8, id8, gnt8, dut.ptr_q, m_busy[0], m_owner[0], eg, m_ptr[0]);
         end
         eg = m_busy[1] ? (4'b0001 << m_owner[1]) : 4'b0000;
         checks++;
         if (busy1 !== m_busy[1] || id1 !== 2'(m_owner[1]) || gnt1 !== eg) begin
            errors++; $display("FAIL random1 t=%0d: got busy=%b id=%0d gnt=%b, want busy=%b id=%0d gnt=%b",
                               t, busy1, id1, gnt1, m_busy[1], m_owner[1], eg);
         end
         rst = ($urandom_range(0, 149) == 0);
         en  = ($urandom_range(0, 7) != 0);
         // Bias toward keeping the current owner's request so long holds occur.
         req = 4'($urandom_range(0, 15));
         if (m_busy[0] && $urandom_range(0, 3) != 0) req[2'(m_owner[0])] = 1'b1;
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; req = 4'b0000;
      test_reset();
      test_first_grant();
      test_rotation();
      test_owner_drop();
      test_enable_drop();
      test_async_reset();
      test_max_hold_one();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
